// File: rtl/clk_div_monitor.sv
// Divided-clock monitor: synchronizes sig_in, measures its period and high time in
// clk_in cycles, declares lock on repeated identical measurements, flags missing edges.

module clk_div_monitor_chk (
    input logic clk_in,
    input logic rst_n,
    input logic locked,
    input logic timeout_err,
    input logic meas_valid,
    input logic in_locked_state
);

    a_locked_tracks_state: assert property (@(posedge clk_in) disable iff (!rst_n)
        locked == in_locked_state);

    a_no_lock_with_timeout: assert property (@(posedge clk_in) disable iff (!rst_n)
        !(locked && timeout_err));

    // A measurement is always triggered by a rise, which clears any pending timeout.
    a_meas_clears_timeout: assert property (@(posedge clk_in) disable iff (!rst_n)
        meas_valid |-> !timeout_err);

endmodule

module clk_div_monitor #(
    parameter int CNT_W      = 8,
    parameter int LOCK_COUNT = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period_o,
    output logic [CNT_W-1:0] high_o,
    output logic             meas_valid,
    output logic             locked,
    output logic             timeout_err
);

    localparam int MATCH_W = $clog2(LOCK_COUNT + 1);

    localparam logic [CNT_W-1:0]   CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]   TIMEOUT_V = CNT_W'(TIMEOUT);
    localparam logic [MATCH_W-1:0] MATCH_ZERO = {MATCH_W{1'b0}};
    localparam logic [MATCH_W-1:0] MATCH_ONE  = MATCH_W'(1);
    localparam logic [MATCH_W-1:0] LOCK_V     = MATCH_W'(LOCK_COUNT);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_FIRST = 2'd1,
        ST_MEASURE    = 2'd2,
        ST_LOCKED     = 2'd3
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val,
                                                 input logic [CNT_W-1:0] lim);
        return (val >= lim) ? lim : val + CNT_ONE;
    endfunction

    logic sync1_r;
    logic sync2_r;
    logic s_d_r;
    logic rise_s;

    state_t state_r;
    state_t state_nxt_s;

    logic [CNT_W-1:0]   per_cnt_r,   per_cnt_nxt_s,   per_run_s;
    logic [CNT_W-1:0]   hi_cnt_r,    hi_cnt_nxt_s,    hi_run_s;
    logic [CNT_W-1:0]   period_r,    period_nxt_s;
    logic [CNT_W-1:0]   high_r,      high_nxt_s;
    logic [MATCH_W-1:0] match_cnt_r, match_cnt_nxt_s, match_upd_s;
    logic               meas_valid_r,  meas_valid_nxt_s;
    logic               locked_r,      locked_nxt_s;
    logic               timeout_err_r, timeout_err_nxt_s;
    logic               meas_match_s;

    // Two-FF synchronizer plus one delay stage for edge detection.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            s_d_r   <= 1'b0;
        end else begin
            sync1_r <= sig_in;
            sync2_r <= sync1_r;
            s_d_r   <= sync2_r;
        end
    end

    assign rise_s       = sync2_r & ~s_d_r;
    assign per_run_s    = rise_s ? CNT_ONE : sat_inc(per_cnt_r, TIMEOUT_V);
    assign hi_run_s     = rise_s ? CNT_ONE : (sync2_r ? sat_inc(hi_cnt_r, CNT_MAX) : hi_cnt_r);
    assign meas_match_s = (per_cnt_r == period_r) && (hi_cnt_r == high_r);

    // Match counter after a measurement; the very first measurement always counts as one.
    assign match_upd_s = (match_cnt_r == MATCH_ZERO) ? MATCH_ONE :
                         !meas_match_s               ? MATCH_ONE :
                         (match_cnt_r >= LOCK_V)     ? LOCK_V    :
                                                       match_cnt_r + MATCH_ONE;

    // FSM state register.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state, counter and output logic; enable low overrides everything.
    always_comb begin
        state_nxt_s       = state_r;
        per_cnt_nxt_s     = per_cnt_r;
        hi_cnt_nxt_s      = hi_cnt_r;
        match_cnt_nxt_s   = match_cnt_r;
        period_nxt_s      = period_r;
        high_nxt_s        = high_r;
        meas_valid_nxt_s  = 1'b0;
        locked_nxt_s      = locked_r;
        timeout_err_nxt_s = timeout_err_r;

        if (!enable) begin
            state_nxt_s       = ST_IDLE;
            per_cnt_nxt_s     = CNT_ZERO;
            hi_cnt_nxt_s      = CNT_ZERO;
            match_cnt_nxt_s   = MATCH_ZERO;
            locked_nxt_s      = 1'b0;
            timeout_err_nxt_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_nxt_s   = ST_WAIT_FIRST;
                    per_cnt_nxt_s = CNT_ZERO;
                    hi_cnt_nxt_s  = CNT_ZERO;
                end

                ST_WAIT_FIRST: begin
                    per_cnt_nxt_s = per_run_s;
                    hi_cnt_nxt_s  = hi_run_s;
                    if (rise_s) begin
                        state_nxt_s       = ST_MEASURE;
                        timeout_err_nxt_s = 1'b0;
                    end else if (per_cnt_r == TIMEOUT_V) begin
                        state_nxt_s       = ST_WAIT_FIRST;
                        per_cnt_nxt_s     = CNT_ZERO;
                        timeout_err_nxt_s = 1'b1;
                        locked_nxt_s      = 1'b0;
                        match_cnt_nxt_s   = MATCH_ZERO;
                    end else begin
                        state_nxt_s = ST_WAIT_FIRST;
                    end
                end

                ST_MEASURE, ST_LOCKED: begin
                    per_cnt_nxt_s = per_run_s;
                    hi_cnt_nxt_s  = hi_run_s;
                    if (rise_s) begin
                        meas_valid_nxt_s  = 1'b1;
                        timeout_err_nxt_s = 1'b0;
                        period_nxt_s      = per_cnt_r;
                        high_nxt_s        = hi_cnt_r;
                        match_cnt_nxt_s   = match_upd_s;
                        if (match_upd_s == LOCK_V) begin
                            state_nxt_s  = ST_LOCKED;
                            locked_nxt_s = 1'b1;
                        end else begin
                            state_nxt_s  = ST_MEASURE;
                            locked_nxt_s = 1'b0;
                        end
                    end else if (per_cnt_r == TIMEOUT_V) begin
                        state_nxt_s       = ST_WAIT_FIRST;
                        per_cnt_nxt_s     = CNT_ZERO;
                        timeout_err_nxt_s = 1'b1;
                        locked_nxt_s      = 1'b0;
                        match_cnt_nxt_s   = MATCH_ZERO;
                    end else begin
                        state_nxt_s = state_r;
                    end
                end

                default: begin
                    state_nxt_s       = ST_IDLE;
                    per_cnt_nxt_s     = CNT_ZERO;
                    hi_cnt_nxt_s      = CNT_ZERO;
                    match_cnt_nxt_s   = MATCH_ZERO;
                    locked_nxt_s      = 1'b0;
                    timeout_err_nxt_s = 1'b0;
                end
            endcase
        end
    end

    // Counters, measurement results and status flags.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            per_cnt_r     <= CNT_ZERO;
            hi_cnt_r      <= CNT_ZERO;
            match_cnt_r   <= MATCH_ZERO;
            period_r      <= CNT_ZERO;
            high_r        <= CNT_ZERO;
            meas_valid_r  <= 1'b0;
            locked_r      <= 1'b0;
            timeout_err_r <= 1'b0;
        end else begin
            per_cnt_r     <= per_cnt_nxt_s;
            hi_cnt_r      <= hi_cnt_nxt_s;
            match_cnt_r   <= match_cnt_nxt_s;
            period_r      <= period_nxt_s;
            high_r        <= high_nxt_s;
            meas_valid_r  <= meas_valid_nxt_s;
            locked_r      <= locked_nxt_s;
            timeout_err_r <= timeout_err_nxt_s;
        end
    end

    assign period_o    = period_r;
    assign high_o      = high_r;
    assign meas_valid  = meas_valid_r;
    assign locked      = locked_r;
    assign timeout_err = timeout_err_r;

    clk_div_monitor_chk u_chk (
        .clk_in          (clk_in),
        .rst_n           (rst_n),
        .locked          (locked_r),
        .timeout_err     (timeout_err_r),
        .meas_valid      (meas_valid_r),
        .in_locked_state (state_r == ST_LOCKED)
    );

endmodule

// File: tb/tb_clk_div_monitor.sv
// Scoreboard bench for clk_div_monitor: expected measurements are derived from the
// driven sig_in waveform and compared whenever the monitor reports meas_valid.

module tb_clk_div_monitor;

    localparam int CNT_W = 8;
    localparam int LOCK  = 4;
    localparam int TMO   = 20;

    logic             clk_in = 1'b0;
    logic             rst_n;
    logic             enable;
    logic             sig_in;
    logic [CNT_W-1:0] period_o;
    logic [CNT_W-1:0] high_o;
    logic             meas_valid;
    logic             locked;
    logic             timeout_err;

    always #5 clk_in = ~clk_in;

    clk_div_monitor #(.CNT_W(CNT_W), .LOCK_COUNT(LOCK), .TIMEOUT(TMO)) dut (
        .clk_in      (clk_in),
        .rst_n       (rst_n),
        .enable      (enable),
        .sig_in      (sig_in),
        .period_o    (period_o),
        .high_o      (high_o),
        .meas_valid  (meas_valid),
        .locked      (locked),
        .timeout_err (timeout_err)
    );

    typedef struct {
        int per;
        int hi;
        bit lk;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state, driven purely by the stimulus.
    bit en_m;
    bit ref_seen;
    int mcnt;
    int exp_per;
    int exp_hi;
    int last_hi;
    int last_lo;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // A rise measures the pulse driven before it (unless it is the reference rise).
    task automatic model_rise(input int hi, input int lo);
        int   per;
        exp_t e;
        if (en_m) begin
            if (!ref_seen) begin
                ref_seen = 1'b1;
            end else begin
                per = last_hi + last_lo;
                if (mcnt == 0)
                    mcnt = 1;
                else if (per == exp_per && last_hi == exp_hi)
                    mcnt = (mcnt < LOCK) ? mcnt + 1 : LOCK;
                else
                    mcnt = 1;
                exp_per = per;
                exp_hi  = last_hi;
                e.per   = per;
                e.hi    = last_hi;
                e.lk    = (mcnt == LOCK);
                sb_q.push_back(e);
            end
        end
        last_hi = hi;
        last_lo = lo;
    endtask

    task automatic pulse(input int hi, input int lo);
        model_rise(hi, lo);
        sig_in = 1'b1;
        repeat (hi) @(negedge clk_in);
        sig_in = 1'b0;
        repeat (lo) @(negedge clk_in);
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_period"},  32'(period_o),    32'd0);
        check_val({tag, "_high"},    32'(high_o),      32'd0);
        check_val({tag, "_mvalid"},  32'(meas_valid),  32'd0);
        check_val({tag, "_locked"},  32'(locked),      32'd0);
        check_val({tag, "_timeout"}, 32'(timeout_err), 32'd0);
    endtask

    // Scoreboard consumer.
    always @(negedge clk_in) begin
        if (rst_n === 1'b1 && meas_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check_val("meas_unexpected", 32'(meas_valid), 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check_val("period_o", 32'(period_o), 32'(mon_e.per));
                check_val("high_o",   32'(high_o),   32'(mon_e.hi));
                check_val("locked_at_meas", 32'(locked), 32'(mon_e.lk));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        int mv_c;
        int to_c;

        rst_n = 1'b0; enable = 1'b0; sig_in = 1'b0;
        en_m = 1'b0; ref_seen = 1'b0; mcnt = 0;
        exp_per = 0; exp_hi = 0; last_hi = 0; last_lo = 0;

        repeat (3) @(negedge clk_in);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk_in);
        enable = 1'b1; en_m = 1'b1;

        // Div-by-7, 3 high / 4 low.
        for (int i = 0; i < 7; i++) pulse(3, 4);
        check_val("locked_div7", 32'(locked), 32'd1);

        // Switch to div-by-6 and relock.
        for (int i = 0; i < 6; i++) pulse(3, 3);
        check_val("locked_div6", 32'(locked), 32'd1);

        // One last rise, then hold low until timeout.
        model_rise(3, 0);
        sig_in = 1'b1;
        c = 0; mv_c = -1; to_c = -1;
        while (to_c < 0 && c < 60) begin
            @(negedge clk_in);
            c++;
            if (c == 3) sig_in = 1'b0;
            if (meas_valid === 1'b1 && mv_c < 0) mv_c = c;
            if (timeout_err === 1'b1 && to_c < 0) to_c = c;
        end
        check_val("timeout_delay", 32'(to_c - mv_c), 32'(TMO));
        check_val("timeout_locked", 32'(locked), 32'd0);
        check_val("timeout_period_hold", 32'(period_o), 32'(exp_per));
        ref_seen = 1'b0; mcnt = 0;

        // Next rise is a reference only and clears the sticky flag.
        model_rise(3, 3);
        sig_in = 1'b1;
        repeat (2) @(negedge clk_in);
        check_val("timeout_sticky", 32'(timeout_err), 32'd1);
        @(negedge clk_in);
        check_val("timeout_clear", 32'(timeout_err), 32'd0);
        sig_in = 1'b0;
        repeat (3) @(negedge clk_in);

        // Relock, then drop enable mid-stream.
        for (int i = 0; i < 7; i++) pulse(3, 4);
        check_val("locked_before_drop", 32'(locked), 32'd1);
        enable = 1'b0; en_m = 1'b0; ref_seen = 1'b0; mcnt = 0;
        @(negedge clk_in);
        check_val("drop_locked", 32'(locked), 32'd0);
        check_val("drop_mvalid", 32'(meas_valid), 32'd0);
        check_val("drop_period_hold", 32'(period_o), 32'(exp_per));
        for (int i = 0; i < 2; i++) pulse(3, 4);
        check_val("off_period_hold", 32'(period_o), 32'(exp_per));
        check_val("off_high_hold", 32'(high_o), 32'(exp_hi));
        enable = 1'b1; en_m = 1'b1;
        for (int i = 0; i < 6; i++) pulse(3, 4);
        check_val("locked_reenable", 32'(locked), 32'd1);

        // Asynchronous reset between edges while locked.
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        exp_per = 0; exp_hi = 0; ref_seen = 1'b0; mcnt = 0;
        repeat (2) @(negedge clk_in);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) pulse(3, 4);
        check_val("locked_after_rst", 32'(locked), 32'd1);

        // Constant-high input still times out via the period counter.
        model_rise(200, 0);
        sig_in = 1'b1;
        c = 0;
        while (timeout_err !== 1'b1 && c < 40) begin
            @(negedge clk_in);
            c++;
        end
        check_val("const_high_timeout", 32'(timeout_err), 32'd1);
        check_val("const_high_locked", 32'(locked), 32'd0);
        sig_in = 1'b0;
        repeat (5) @(negedge clk_in);
        check_val("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
